digit_serial_add_sub: RTL and testbench

Parametrised digit-serial adder/subtractor, the successor to our bit-serial adder with valid. Operands stream in LSB digit first, `DIGIT_W` bits per cycle, under a valid qualifier; `last` ends a word. Per word the block selects add or subtract, enforces a maximum word length, and reports carry/borrow and signed overflow with the final digit. It sits between serial operand sources and a digit-serial result sink, with registered outputs.

---
 rtl/digit_serial_add_sub.sv | 124 ++++++++++++
 tb/tb_digit_serial_add_sub.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_add_sub.sv
// Digit-serial adder/subtractor: LSB-first operand digits under a valid qualifier,
// one registered result digit per accepted digit, word-end carry/overflow/length flags.
//
// state  | meaning
// S_IDLE | waiting for the first digit of a word; mode and carry-in come from i_sub
// S_BUSY | inside a word; mode from r_sub_q, carry-in from r_carry
module digit_serial_add_sub #(
   parameter int DIGIT_W    = 4,
   parameter int MAX_DIGITS = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_vld,
   input  logic               i_sub,
   input  logic [DIGIT_W-1:0] i_a,
   input  logic [DIGIT_W-1:0] i_b,
   input  logic               i_last,
   output logic               o_out_vld,
   output logic [DIGIT_W-1:0] o_sum,
   output logic               o_out_last,
   output logic               o_carry_out,
   output logic               o_overflow,
   output logic               o_len_err
);

   localparam int               CNT_W    = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_DIGITS - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_carry;
   logic               r_sub_q;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_mode;
   logic               w_cin;
   logic               w_end;
   logic               w_c;
   logic               w_ovf;
   logic               w_carry_nxt;
   logic               w_sub_q_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [DIGIT_W-1:0] w_b_eff;
   logic [DIGIT_W-1:0] w_s;
   logic [DIGIT_W:0]   w_total;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_carry <= 1'b0;
         r_sub_q <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_carry <= w_carry_nxt;
         r_sub_q <= w_sub_q_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_carry_nxt = r_carry;
      w_sub_q_nxt = r_sub_q;
      w_cnt_nxt   = r_cnt;
      w_mode      = r_sub_q;
      w_cin       = r_carry;

      // Subtraction is a + ~b + 1: the first digit injects the +1 as carry-in.
      if (r_state == S_IDLE) begin
         w_mode = i_sub;
         w_cin  = i_sub;
      end

      w_b_eff = w_mode ? ~i_b : i_b;
      w_total = {1'b0, i_a} + {1'b0, w_b_eff} + {{DIGIT_W{1'b0}}, w_cin};
      w_c     = w_total[DIGIT_W];
      w_s     = w_total[DIGIT_W-1:0];
      w_end   = i_last || (r_cnt == CNT_LAST);
      w_ovf   = (i_a[DIGIT_W-1] == w_b_eff[DIGIT_W-1]) && (w_s[DIGIT_W-1] != i_a[DIGIT_W-1]);

      if (i_vld) begin
         w_sub_q_nxt = w_mode;
         if (w_end) begin
            w_state_nxt = S_IDLE;
            w_carry_nxt = 1'b0;
            w_cnt_nxt   = '0;
         end else begin
            w_state_nxt = S_BUSY;
            w_carry_nxt = w_c;
            w_cnt_nxt   = r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_out_vld   <= 1'b0;
         o_sum       <= '0;
         o_out_last  <= 1'b0;
         o_carry_out <= 1'b0;
         o_overflow  <= 1'b0;
         o_len_err   <= 1'b0;
      end else begin
         o_out_vld  <= i_vld;
         o_out_last <= i_vld && w_end;
         o_len_err  <= i_vld && w_end && !i_last;
         if (i_vld) begin
            o_sum <= w_s;
         end
         // Word flags hold between word ends so the sink may sample them late.
         if (i_vld && w_end) begin
            o_carry_out <= w_c;
            o_overflow  <= w_ovf;
         end
      end
   end

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Bench for digit_serial_add_sub: directed word table, multi-cycle corner sequences
// and random words checked against a word-level arithmetic model.
module tb_digit_serial_add_sub;

   logic       clk;
   logic       rst_n;
   logic       vld;
   logic       sub;
   logic [3:0] a;
   logic [3:0] b;
   logic       last;
   logic       out_vld;
   logic [3:0] sum;
   logic       out_last;
   logic       carry_out;
   logic       overflow;
   logic       len_err;

   int checks = 0;
   int errors = 0;

   digit_serial_add_sub #(.DIGIT_W(4), .MAX_DIGITS(8)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_vld       (vld),
      .i_sub       (sub),
      .i_a         (a),
      .i_b         (b),
      .i_last      (last),
      .o_out_vld   (out_vld),
      .o_sum       (sum),
      .o_out_last  (out_last),
      .o_carry_out (carry_out),
      .o_overflow  (overflow),
      .o_len_err   (len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      int          n;
      logic [31:0] aw;
      logic [31:0] bw;
      logic        sb;
      bit          tog;
      bit          gaps;
      logic [31:0] exp_sum;
      logic        exp_c;
      logic        exp_ov;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Word-level reference: signed range test for overflow, unsigned compare for carry.
   function automatic void model(input int n, input longint aw, input longint bw, input bit sb,
                                 output longint es, output bit ec, output bit eo);
      longint w;
      longint half;
      longint sa;
      longint sv;
      longint r;
      longint u;
      w    = longint'(1) << (4 * n);
      half = w / 2;
      sa   = (aw >= half) ? aw - w : aw;
      sv   = (bw >= half) ? bw - w : bw;
      r    = sb ? sa - sv : sa + sv;
      eo   = (r >= half) || (r < -half);
      u    = sb ? aw - bw : aw + bw;
      es   = ((u % w) + w) % w;
      ec   = sb ? (aw >= bw) : ((aw + bw) >= w);
   endfunction

   task automatic run_word(input int n, input logic [31:0] aw, input logic [31:0] bw,
                           input logic sb, input bit tog, input bit gaps,
                           output logic [31:0] s, output logic c, output logic ov);
      s = '0;
      for (int i = 0; i < n; i++) begin
         if (gaps && i > 0) begin
            int g;
            g = $urandom_range(1, 3);
            for (int k = 0; k < g; k++) begin
               @(negedge clk);
               vld  = 1'b0;
               a    = 4'($urandom);
               b    = 4'($urandom);
               sub  = 1'($urandom);
               last = 1'($urandom);
               @(posedge clk); #1;
               chk("gap_out_vld", 64'(out_vld), 64'(0));
               chk("gap_out_last", 64'(out_last), 64'(0));
            end
         end
         @(negedge clk);
         vld  = 1'b1;
         a    = aw[4*i +: 4];
         b    = bw[4*i +: 4];
         sub  = (i == 0) ? sb : (tog ? ~sb : sb);
         last = (i == n - 1);
         @(posedge clk); #1;
         chk("out_vld", 64'(out_vld), 64'(1));
         chk("out_last", 64'(out_last), 64'(i == n - 1));
         chk("len_err", 64'(len_err), 64'(0));
         s[4*i +: 4] = sum;
      end
      c  = carry_out;
      ov = overflow;
   endtask

   vec_t        tbl[9];
   logic [31:0] got_s;
   logic        got_c;
   logic        got_ov;
   longint      es;
   bit          ec;
   bit          eo;

   initial begin
      tbl[0] = '{4, 32'h00FF, 32'h0001, 1'b0, 1'b0, 1'b0, 32'h0100, 1'b0, 1'b0};
      tbl[1] = '{2, 32'h03,   32'h05,   1'b1, 1'b0, 1'b0, 32'hFE,   1'b0, 1'b0};
      tbl[2] = '{2, 32'h03,   32'h05,   1'b1, 1'b1, 1'b0, 32'hFE,   1'b0, 1'b0};
      tbl[3] = '{2, 32'h7F,   32'h01,   1'b0, 1'b0, 1'b0, 32'h80,   1'b0, 1'b1};
      tbl[4] = '{2, 32'hFF,   32'h01,   1'b0, 1'b0, 1'b0, 32'h00,   1'b1, 1'b0};
      tbl[5] = '{4, 32'h00FF, 32'h0001, 1'b0, 1'b0, 1'b1, 32'h0100, 1'b0, 1'b0};
      tbl[6] = '{1, 32'hF,    32'h1,    1'b1, 1'b0, 1'b0, 32'hE,    1'b1, 1'b0};
      tbl[7] = '{1, 32'h8,    32'h8,    1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1};
      tbl[8] = '{1, 32'h1,    32'h1,    1'b0, 1'b0, 1'b0, 32'h2,    1'b0, 1'b0};

      rst_n = 1'b0;
      vld   = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      last  = 1'b0;
      #1;
      chk("rst_out_vld", 64'(out_vld), 64'(0));
      chk("rst_sum", 64'(sum), 64'(0));
      chk("rst_out_last", 64'(out_last), 64'(0));
      chk("rst_carry_out", 64'(carry_out), 64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
      chk("rst_len_err", 64'(len_err), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 9; t++) begin
         run_word(tbl[t].n, tbl[t].aw, tbl[t].bw, tbl[t].sb, tbl[t].tog, tbl[t].gaps,
                  got_s, got_c, got_ov);
         chk($sformatf("tbl%0d_sum", t), 64'(got_s), 64'(tbl[t].exp_sum));
         chk($sformatf("tbl%0d_carry", t), 64'(got_c), 64'(tbl[t].exp_c));
         chk($sformatf("tbl%0d_ovf", t), 64'(got_ov), 64'(tbl[t].exp_ov));
      end

      // Nine F+0 digits without last: forced end on the 8th, 9th is a fresh subtract word.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         vld  = 1'b1;
         a    = 4'hF;
         b    = 4'h0;
         sub  = (i == 8);
         last = (i == 8);
         @(posedge clk); #1;
         chk($sformatf("len_sum%0d", i), 64'(sum), 64'(4'hF));
         if (i < 8) begin
            chk($sformatf("len_out_last%0d", i), 64'(out_last), 64'(i == 7));
            chk($sformatf("len_err%0d", i), 64'(len_err), 64'(i == 7));
         end else begin
            chk("restart_out_last", 64'(out_last), 64'(1));
            chk("restart_len_err", 64'(len_err), 64'(0));
            chk("restart_carry", 64'(carry_out), 64'(1));
            chk("restart_ovf", 64'(overflow), 64'(0));
         end
      end

      // Reset mid-word after two F+1 digits (carry pending), then a clean 1+1.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vld  = 1'b1;
         a    = 4'hF;
         b    = 4'h1;
         sub  = 1'b0;
         last = 1'b0;
         @(posedge clk); #1;
      end
      chk("pre_rst_sum", 64'(sum), 64'(4'h1));
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_vld", 64'(out_vld), 64'(0));
      chk("async_rst_sum", 64'(sum), 64'(0));
      chk("async_rst_carry_out", 64'(carry_out), 64'(0));
      @(posedge clk); #1;
      chk("held_rst_out_vld", 64'(out_vld), 64'(0));
      chk("held_rst_sum", 64'(sum), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      vld   = 1'b1;
      a     = 4'h1;
      b     = 4'h1;
      sub   = 1'b0;
      last  = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_sum", 64'(sum), 64'(4'h2));
      chk("post_rst_carry", 64'(carry_out), 64'(0));
      chk("post_rst_out_last", 64'(out_last), 64'(1));

      for (int r = 0; r < 60; r++) begin
         int          n;
         logic [31:0] aw;
         logic [31:0] bw;
         logic        sb;
         logic [31:0] mask;
         n    = $urandom_range(1, 8);
         mask = (n == 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * n)) - 32'h1);
         aw   = $urandom & mask;
         bw   = $urandom & mask;
         sb   = 1'($urandom);
         model(n, longint'(aw), longint'(bw), sb, es, ec, eo);
         run_word(n, aw, bw, sb, 1'($urandom), ($urandom_range(0, 3) == 0), got_s, got_c, got_ov);
         chk($sformatf("rnd%0d_sum", r), 64'(got_s), 64'(es));
         chk($sformatf("rnd%0d_carry", r), 64'(got_c), 64'(ec));
         chk($sformatf("rnd%0d_ovf", r), 64'(got_ov), 64'(eo));
      end

      @(negedge clk);
      vld = 1'b0;
      @(posedge clk); #1;
      chk("idle_out_vld", 64'(out_vld), 64'(0));
      chk("idle_carry_hold", 64'(carry_out), 64'(got_c));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
